// File: rtl/jtag_ahb_master_pkg.sv
// Shared types for the JTAG-to-AHB single-transfer master.
package jtag_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_e;

endpackage

// File: rtl/jtag_ahb_master_if.sv
// Command/response handshake plus AHB-Lite master signals, seen from the master (DUT) or the slave side.
interface jtag_ahb_master_if
    import jtag_ahb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STALL_W = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_write;
    logic               cmd_autoinc;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [DATA_W-1:0]  cmd_wdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_rdata;
    logic               rsp_err;
    logic [STALL_W-1:0] rsp_stall;
    logic               HREADY;
    logic               HRESP;
    logic [DATA_W-1:0]  HRDATA;
    logic [ADDR_W-1:0]  HADDR;
    htrans_e            HTRANS;
    logic               HWRITE;
    logic [2:0]         HSIZE;
    logic [DATA_W-1:0]  HWDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_autoinc, cmd_addr, cmd_wdata, rsp_ready,
               HREADY, HRESP, HRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_stall,
               HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_autoinc, cmd_addr, cmd_wdata, rsp_ready,
               HREADY, HRESP, HRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_stall,
               HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );

endinterface

// File: rtl/jtag_ahb_master.sv
// Runs one AHB-Lite NONSEQ transfer per accepted debug command and returns data, error and wait-state count.
module jtag_ahb_master
    import jtag_ahb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int STALL_W   = 16,
    parameter int ADDR_STEP = 4
) (
    input logic               HCLK,
    input logic               HRESET,
    jtag_ahb_master_if.master bus
);

    state_e             state_q, state_d;
    logic               cmd_ready_q;
    logic [ADDR_W-1:0]  haddr_q, haddr_d;
    logic               hwrite_q, hwrite_d;
    logic [DATA_W-1:0]  hwdata_q, hwdata_d;
    logic               err_q, err_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rsp_err_q, rsp_err_d;

    // haddr_q doubles as last_addr: it is only rewritten when a new command is accepted.
    always_comb begin
        state_d   = state_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        hwdata_d  = hwdata_q;
        err_d     = err_q;
        stall_d   = stall_q;
        rdata_d   = rdata_q;
        rsp_err_d = rsp_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    haddr_d  = bus.cmd_autoinc ? haddr_q + ADDR_W'(ADDR_STEP) : bus.cmd_addr;
                    hwrite_d = bus.cmd_write;
                    hwdata_d = bus.cmd_wdata;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus.HREADY) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (!bus.HREADY) begin
                    if (stall_q != '1) stall_d = stall_q + 1'b1;
                    if (bus.HRESP) err_d = 1'b1;
                end else begin
                    rdata_d   = hwrite_q ? '0 : bus.HRDATA;
                    rsp_err_d = err_q | bus.HRESP;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                    stall_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            err_q       <= 1'b0;
            stall_q     <= '0;
            rdata_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
            rdata_q     <= rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_stall = stall_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = HSIZE_WORD;
    assign bus.HWDATA    = hwdata_q;

endmodule

// File: tb/tb_jtag_ahb_master.sv
// Vector table of single transfers with a response scoreboard, plus reset and hold corner sequences.
module tb_jtag_ahb_master;
    import jtag_ahb_pkg::*;

    logic HCLK;
    logic HRESET;
    int   tests = 0;
    int   fails = 0;

    jtag_ahb_master_if #(.ADDR_W(32), .DATA_W(32), .STALL_W(16)) bus ();

    jtag_ahb_master #(.ADDR_W(32), .DATA_W(32), .STALL_W(16), .ADDR_STEP(4)) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        wr;
        logic        ai;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] sdata;
        int          aw;
        int          dw;
        logic        serr;
        logic        hold;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [15:0] exp_stall;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] stall;
    } rsp_t;

    rsp_t sb[$];
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic ai, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] sdata,
                                input int aw, input int dw, input logic serr, input logic hold,
                                input logic [31:0] ea, input logic [31:0] er,
                                input logic ee, input logic [15:0] es);
        vec_t v;
        v.wr = wr; v.ai = ai; v.addr = addr; v.wdata = wdata; v.sdata = sdata;
        v.aw = aw; v.dw = dw; v.serr = serr; v.hold = hold;
        v.exp_addr = ea; v.exp_rdata = er; v.exp_err = ee; v.exp_stall = es;
        return v;
    endfunction

    // Responses are compared as they are consumed.
    always @(negedge HCLK) begin
        rsp_t e;
        if (!HRESET && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                chk("rsp_err",   64'(bus.rsp_err),   64'(e.err));
                chk("rsp_stall", 64'(bus.rsp_stall), 64'(e.stall));
            end
        end
    end

    task automatic issue(input vec_t v, input int idx, output bit ok);
        int n = 0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_write   = v.wr;
        bus.cmd_autoinc = v.ai;
        bus.cmd_addr    = v.addr;
        bus.cmd_wdata   = v.wdata;
        bus.rsp_ready   = !v.hold;
        bus.HREADY      = 1'b1;
        bus.HRESP       = 1'b0;
        @(negedge HCLK);
        while (!bus.cmd_ready && n < 20) begin
            @(negedge HCLK);
            n++;
        end
        ok = bus.cmd_ready;
        if (!ok) begin
            chk($sformatf("v%0d_handshake_timeout", idx), 64'd0, 64'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge HCLK); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_write = ~v.wr;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        issue(v, idx, ok);
        if (!ok) return;
        sb.push_back('{v.exp_rdata, v.exp_err, v.exp_stall});
        // Address phase, optionally extended by the slave.
        for (int i = 0; i < v.aw; i++) begin
            bus.HREADY = 1'b0;
            @(negedge HCLK);
            chk($sformatf("v%0d_aw_htrans", idx), 64'(bus.HTRANS), 64'(HTRANS_NONSEQ));
            chk($sformatf("v%0d_aw_haddr", idx), 64'(bus.HADDR), 64'(v.exp_addr));
            chk($sformatf("v%0d_aw_cmd_ready", idx), 64'(bus.cmd_ready), 64'd0);
            @(posedge HCLK); #1;
        end
        bus.HREADY = 1'b1;
        @(negedge HCLK);
        chk($sformatf("v%0d_htrans_nonseq", idx), 64'(bus.HTRANS), 64'(HTRANS_NONSEQ));
        chk($sformatf("v%0d_haddr", idx), 64'(bus.HADDR), 64'(v.exp_addr));
        chk($sformatf("v%0d_hwrite", idx), 64'(bus.HWRITE), 64'(v.wr));
        chk($sformatf("v%0d_hsize", idx), 64'(bus.HSIZE), 64'h2);
        @(posedge HCLK); #1;
        // Data phase wait states; an error response ends with its second cycle below.
        for (int i = 0; i < v.dw; i++) begin
            bus.HREADY = 1'b0;
            bus.HRESP  = v.serr && (i == v.dw - 1);
            bus.HRDATA = $urandom;
            @(negedge HCLK);
            if (i < 3) begin
                chk($sformatf("v%0d_dw_htrans", idx), 64'(bus.HTRANS), 64'(HTRANS_IDLE));
                if (v.wr) chk($sformatf("v%0d_dw_hwdata", idx), 64'(bus.HWDATA), 64'(v.wdata));
            end
            @(posedge HCLK); #1;
        end
        bus.HREADY = 1'b1;
        bus.HRESP  = v.serr;
        bus.HRDATA = v.sdata;
        @(negedge HCLK);
        chk($sformatf("v%0d_data_htrans", idx), 64'(bus.HTRANS), 64'(HTRANS_IDLE));
        if (v.wr) chk($sformatf("v%0d_hwdata", idx), 64'(bus.HWDATA), 64'(v.wdata));
        chk($sformatf("v%0d_rsp_early", idx), 64'(bus.rsp_valid), 64'd0);
        @(posedge HCLK); #1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = $urandom;
        @(negedge HCLK);
        chk($sformatf("v%0d_rsp_valid", idx), 64'(bus.rsp_valid), 64'd1);
        if (v.hold) begin
            for (int k = 0; k < 5; k++) begin
                @(posedge HCLK); #1;
                @(negedge HCLK);
                chk($sformatf("v%0d_hold_valid", idx), 64'(bus.rsp_valid), 64'd1);
                chk($sformatf("v%0d_hold_rdata", idx), 64'(bus.rsp_rdata), 64'(v.exp_rdata));
                chk($sformatf("v%0d_hold_cmd_ready", idx), 64'(bus.cmd_ready), 64'd0);
            end
            @(posedge HCLK); #1;
            bus.rsp_ready = 1'b1;
        end
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk($sformatf("v%0d_back_idle", idx), 64'(bus.cmd_ready), 64'd1);
        chk($sformatf("v%0d_rsp_dropped", idx), 64'(bus.rsp_valid), 64'd0);
        @(posedge HCLK); #1;
    endtask

    initial begin
        bit   ok;
        vec_t v;

        vecs[0] = mk(1, 0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h1111_1111, 0, 0, 0, 0,
                     32'h0000_1000, 32'h0, 0, 16'd0);
        vecs[1] = mk(0, 0, 32'h0000_2000, 32'h0, 32'h1234_5678, 0, 3, 0, 0,
                     32'h0000_2000, 32'h1234_5678, 0, 16'd3);
        vecs[2] = mk(1, 0, 32'h0000_3000, 32'h0BAD_F00D, 32'h0, 2, 0, 0, 0,
                     32'h0000_3000, 32'h0, 0, 16'd0);
        vecs[3] = mk(0, 0, 32'h0000_4000, 32'h0, 32'h55AA_55AA, 0, 1, 1, 0,
                     32'h0000_4000, 32'h55AA_55AA, 1, 16'd1);
        vecs[4] = mk(0, 1, 32'h9999_0000, 32'h0, 32'hA5A5_A5A5, 0, 2, 0, 0,
                     32'h0000_4004, 32'hA5A5_A5A5, 0, 16'd2);
        vecs[5] = mk(1, 0, 32'hFFFF_FFFC, 32'h1111_2222, 32'h7777_7777, 0, 1, 0, 0,
                     32'hFFFF_FFFC, 32'h0, 0, 16'd1);
        vecs[6] = mk(1, 1, 32'h1234_0000, 32'h3333_4444, 32'h0, 0, 0, 0, 0,
                     32'h0000_0000, 32'h0, 0, 16'd0);
        vecs[7] = mk(0, 0, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 1, 0, 0, 1,
                     32'h0000_5000, 32'hCAFE_F00D, 0, 16'd0);
        vecs[8] = mk(0, 0, 32'h0000_7000, 32'h0, 32'h0F0F_0F0F, 0, 65537, 0, 0,
                     32'h0000_7000, 32'h0F0F_0F0F, 0, 16'hFFFF);
        vecs[9] = mk(0, 1, 32'h0000_8000, 32'h0, 32'h2468_ACE0, 0, 0, 0, 0,
                     32'h0000_0004, 32'h2468_ACE0, 0, 16'd0);

        HRESET          = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_autoinc = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_wdata   = '0;
        bus.rsp_ready   = 1'b0;
        bus.HREADY      = 1'b1;
        bus.HRESP       = 1'b0;
        bus.HRDATA      = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
        chk("rst_rsp_stall", 64'(bus.rsp_stall), 64'd0);
        chk("rst_haddr",     64'(bus.HADDR),     64'd0);
        chk("rst_htrans",    64'(bus.HTRANS),    64'(HTRANS_IDLE));
        chk("rst_hwrite",    64'(bus.HWRITE),    64'd0);
        chk("rst_hwdata",    64'(bus.HWDATA),    64'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(posedge HCLK); #1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset while the data phase is stalled drops the transfer silently.
        v = mk(0, 0, 32'h0000_6000, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0000_6000, 32'h0, 0, 16'd0);
        issue(v, 100, ok);
        if (ok) begin
            @(negedge HCLK);
            chk("rd_htrans_nonseq", 64'(bus.HTRANS), 64'(HTRANS_NONSEQ));
            @(posedge HCLK); #1;
            bus.HREADY = 1'b0;
            repeat (2) @(posedge HCLK);
            #1;
            HRESET = 1'b1;
            @(posedge HCLK); #1;
            @(negedge HCLK);
            chk("rd_htrans_idle", 64'(bus.HTRANS),    64'(HTRANS_IDLE));
            chk("rd_rsp_valid",   64'(bus.rsp_valid), 64'd0);
            chk("rd_cmd_ready",   64'(bus.cmd_ready), 64'd0);
            chk("rd_haddr",       64'(bus.HADDR),     64'd0);
            chk("rd_rsp_stall",   64'(bus.rsp_stall), 64'd0);
            @(posedge HCLK); #1;
            HRESET     = 1'b0;
            bus.HREADY = 1'b1;
            bus.rsp_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge HCLK);
                chk("rd_no_rsp", 64'(bus.rsp_valid), 64'd0);
                @(posedge HCLK); #1;
            end
        end

        // last_addr restarts from zero after reset.
        run_vec(vecs[9], 9);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
